// File: rtl/snd_latch_irq.sv
// snd_latch_irq
//   Sound-side endpoint of the main-CPU -> sound-CPU command path.
//   Holds the command byte written by the main CPU for the Z80, raises the
//   Z80 IM0 interrupt, merges it with the YM2151 IRQ into an Irem-style
//   RST vector, and carries the Z80 reply byte back to the main CPU.
//
// Ports
//   clk_sys        in   clock, all state on rising edge
//   reset          in   synchronous active-high reset
//   latch_wr/din   in   main-CPU command write strobe / byte
//   latch_rd       in   main-CPU reply read strobe
//   latch_dout     out  reply byte
//   latch_rdy      out  reply pending
//   z80_cmd_rd     in   Z80 command-port read (no side effect)
//   z80_cmd_dout   out  command byte
//   z80_cmd_ack    in   Z80 strobe clearing the command interrupt
//   z80_reply_wr/din in Z80 reply write strobe / byte
//   ym_irq_n       in   YM2151 IRQ, active low level
//   z80_intack     in   Z80 interrupt-acknowledge cycle, level
//   z80_int_n      out  Z80 INT, active low, registered
//   z80_vector     out  IM0 vector (RST opcode)
//   overrun        out  sticky: command overwritten before ack
//
// Acknowledge FSM
//   state   | meaning
//   ST_IDLE | no acknowledge in progress, vector output idles at VEC_IDLE
//   ST_ACK  | acknowledge cycle active, vector captured at intack rise is held

module snd_latch_irq #(
  parameter logic [7:0] VEC_IDLE = 8'hFF,
  parameter int         CMD_BIT  = 5,
  parameter int         YM_BIT   = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       latch_wr,
  input  logic [7:0] latch_din,
  input  logic       latch_rd,
  output logic [7:0] latch_dout,
  output logic       latch_rdy,
  input  logic       z80_cmd_rd,
  output logic [7:0] z80_cmd_dout,
  input  logic       z80_cmd_ack,
  input  logic       z80_reply_wr,
  input  logic [7:0] z80_reply_din,
  input  logic       ym_irq_n,
  input  logic       z80_intack,
  output logic       z80_int_n,
  output logic [7:0] z80_vector,
  output logic       overrun
);

  typedef enum logic {ST_IDLE, ST_ACK} ack_state_t;

  logic [7:0] cmd_q;
  logic       cmd_pend;
  logic [7:0] reply_q;
  logic       reply_pend;
  logic       ym_act_q;
  logic       intack_q;
  logic [7:0] vec_q;
  logic [7:0] live_vec;
  logic       capture;
  ack_state_t ack_state, ack_next;

  // Command port reads have no side effect; the strobe is not needed.
  logic unused_cmd_rd;
  assign unused_cmd_rd = z80_cmd_rd;

  // Command latch: a write in the same cycle as an ack wins and is not an
  // overrun, since the Z80 has already consumed the previous byte.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cmd_q    <= 8'h00;
      cmd_pend <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (latch_wr) begin
        cmd_q    <= latch_din;
        cmd_pend <= 1'b1;
        if (cmd_pend && !z80_cmd_ack)
          overrun <= 1'b1;
      end else if (z80_cmd_ack) begin
        cmd_pend <= 1'b0;
      end
    end
  end

  // Reply latch: a new reply in the same cycle as the main-CPU read wins.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      reply_q    <= 8'h00;
      reply_pend <= 1'b0;
    end else begin
      if (z80_reply_wr) begin
        reply_q    <= z80_reply_din;
        reply_pend <= 1'b1;
      end else if (latch_rd) begin
        reply_pend <= 1'b0;
      end
    end
  end

  // The YM level is registered once so both interrupt sources reach INT
  // with the same two-cycle latency; it is a same-clock input, not a CDC.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ym_act_q  <= 1'b0;
      z80_int_n <= 1'b1;
      intack_q  <= 1'b0;
    end else begin
      ym_act_q  <= ~ym_irq_n;
      z80_int_n <= (live_vec == VEC_IDLE);
      intack_q  <= z80_intack;
    end
  end

  always_comb begin
    live_vec = VEC_IDLE;
    if (cmd_pend) live_vec[CMD_BIT] = 1'b0;
    if (ym_act_q) live_vec[YM_BIT]  = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ack_state <= ST_IDLE;
      vec_q     <= VEC_IDLE;
    end else begin
      ack_state <= ack_next;
      if (capture)
        vec_q <= live_vec;
    end
  end

  // Capture only on a fresh intack rise so the vector stays frozen for the
  // whole acknowledge cycle even if sources change underneath it.
  always_comb begin
    ack_next = ack_state;
    capture  = 1'b0;
    case (ack_state)
      ST_IDLE: begin
        if (z80_intack && !intack_q) begin
          capture  = 1'b1;
          ack_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!z80_intack)
          ack_next = ST_IDLE;
      end
      default: ack_next = ST_IDLE;
    endcase
  end

  assign z80_vector   = (ack_state == ST_ACK) ? vec_q : VEC_IDLE;
  assign z80_cmd_dout = cmd_q;
  assign latch_dout   = reply_q;
  assign latch_rdy    = reply_pend;

endmodule

// File: doc/snd_latch_irq.md
# snd_latch_irq

Sound-side endpoint of the main-CPU-to-sound-CPU command path. The main V33 writes command bytes through its `latch_wr` strobe. This block holds each byte for the Z80 sound CPU and raises the Z80 IM0 interrupt. It merges that interrupt with the YM2151 IRQ into the Irem RST vector scheme. It also carries the sound CPU's reply byte back, which the main CPU reads via `latch_rd`/`latch_dout`/`latch_rdy`. It sits inside `sound`, between the main-bus latch strobes and the Z80 I/O decode.

## Interface
Parameters:
- `VEC_IDLE`, default 8'hFF: vector with no source pending (RST 38h).
- `CMD_BIT`, default 5: vector bit cleared while a command is pending (gives DFh).
- `YM_BIT`, default 4: vector bit cleared while the YM IRQ is active (gives EFh).

Ports:
- `clk_sys`, in, 1: the single clock; all state is on its rising edge.
- `reset`, in, 1: synchronous, active-high; the parent drives it as `sound_reset | ~reset_n`.
- `latch_wr`, in, 1: main-CPU command write strobe, one cycle.
- `latch_din`, in, 8: command byte.
- `latch_rd`, in, 1: main-CPU reply read strobe, one cycle.
- `latch_dout`, out, 8: reply byte.
- `latch_rdy`, out, 1: a reply is pending for the main CPU.
- `z80_cmd_rd`, in, 1: Z80 read strobe for the command port.
- `z80_cmd_dout`, out, 8: command byte as seen by the Z80.
- `z80_cmd_ack`, in, 1: Z80 write strobe that clears the command interrupt.
- `z80_reply_wr`, in, 1: Z80 reply write strobe.
- `z80_reply_din`, in, 8: reply byte.
- `ym_irq_n`, in, 1: YM2151 IRQ, active low, level.
- `z80_intack`, in, 1: Z80 interrupt-acknowledge cycle (M1 and IORQ both low), level.
- `z80_int_n`, out, 1: Z80 INT, active low.
- `z80_vector`, out, 8: IM0 vector driven during `z80_intack`.
- `overrun`, out, 1: sticky flag; a command was overwritten before it was acked.

## Operation
- Command register `cmd_q` (8 bit) and flag `cmd_pend`.
  - `latch_wr`: `cmd_q <= latch_din`, `cmd_pend <= 1`.
  - `latch_wr` while `cmd_pend`=1 and no `z80_cmd_ack` in the same cycle: also sets `overrun`.
- `z80_cmd_rd` has no side effect. `z80_cmd_dout = cmd_q` combinationally.
- `z80_cmd_ack` clears `cmd_pend`. If `latch_wr` occurs in the same cycle, the write wins: `cmd_pend` stays 1, new data is stored, and `overrun` is not set.
- Reply register `reply_q` and flag `reply_pend`.
  - `z80_reply_wr`: `reply_q <= z80_reply_din`, `reply_pend <= 1`.
  - `latch_rd` clears `reply_pend`. If `z80_reply_wr` occurs in the same cycle, the set wins.
  - `latch_dout = reply_q`, `latch_rdy = reply_pend`.
- Live vector: `VEC_IDLE`, with bit `CMD_BIT` cleared when `cmd_pend`, and bit `YM_BIT` cleared when `ym_irq_n`=0.
- Combined values: both sources active gives CFh; neither gives FFh.
- `z80_int_n` is registered: next value is (live vector == `VEC_IDLE`).
- Acknowledge state machine:
  - IDLE: on a `z80_intack` rising edge (detected against a registered copy), capture the live vector into `vec_q` and go to ACK.
  - ACK: hold `vec_q`; return to IDLE when `z80_intack` falls.
  - `z80_vector = vec_q` in ACK, `VEC_IDLE` in IDLE.
  - Source changes during ACK do not alter the vector being driven.
- Acknowledge does not clear any source. The Z80 handler must issue `z80_cmd_ack`; the YM IRQ clears at the YM itself.
- Only `reset` clears `overrun`.

## Timing
- Reset values:
  - `cmd_q`=00h, `reply_q`=00h; `cmd_pend`=0, `reply_pend`=0.
  - `overrun`=0, `z80_int_n`=1, `z80_vector`=FFh.
  - Acknowledge state IDLE.
- Reset mid-operation discards pending data and returns the acknowledge state machine to IDLE in the next cycle.
- Latencies:
  - `latch_wr` in cycle N: `cmd_pend`/`z80_cmd_dout` valid at N+1; `z80_int_n` low at N+2.
  - `z80_cmd_ack` in cycle N: `z80_int_n` high at N+2, provided the YM IRQ is inactive.
  - `ym_irq_n` falling in cycle N: `z80_int_n` low at N+2. There is no synchronizer; the input is same-clock.
  - `z80_intack` rising in cycle N: `z80_vector` valid at N+1, held until the cycle after `z80_intack` falls.
  - Reply path: `latch_rdy` rises at N+1 after `z80_reply_wr`, and falls at N+1 after `latch_rd`.
- All strobes are single-cycle. A strobe held for k cycles acts as k events; this is harmless except for `overrun`.

## Test plan
- Reset, then `latch_wr` with 5Ah → `z80_cmd_dout`=5Ah and `z80_int_n`=0 two cycles later; `z80_intack` → `z80_vector`=DFh; `z80_cmd_ack` → `z80_int_n`=1 two cycles later.
- `ym_irq_n`=0 with a command pending, then `z80_intack` → vector CFh. Release `ym_irq_n` during ACK → vector stays CFh until intack drops. The next intack gives DFh.
- Two `latch_wr` (11h, then 22h) with no ack → `z80_cmd_dout`=22h, `overrun`=1. Write 33h in the same cycle as `z80_cmd_ack` → `cmd_pend`=1, `overrun` unchanged.
- `z80_reply_wr` with A5h → `latch_rdy`=1, `latch_dout`=A5h. `latch_rd` in the same cycle as a second reply write of 3Ch → `latch_rdy` stays 1, `latch_dout`=3Ch.
- Assert `reset` while in ACK with a command pending → next cycle `z80_int_n`=1, `z80_vector`=FFh, `latch_rdy`=0, `overrun`=0.
- YM only: `ym_irq_n`=0 → intack vector EFh; no source → `z80_int_n` stays 1 and the vector is FFh.
